// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad controller.
//   - key codes (code = 4*row + col of the 4x4 keypad)
//   - sequencing FSM state type
//   - keypad decode helpers
package calc_pkg;

    localparam logic [3:0] KEY_1   = 4'd0;
    localparam logic [3:0] KEY_2   = 4'd1;
    localparam logic [3:0] KEY_3   = 4'd2;
    localparam logic [3:0] KEY_ADD = 4'd3;
    localparam logic [3:0] KEY_4   = 4'd4;
    localparam logic [3:0] KEY_5   = 4'd5;
    localparam logic [3:0] KEY_6   = 4'd6;
    localparam logic [3:0] KEY_SUB = 4'd7;
    localparam logic [3:0] KEY_7   = 4'd8;
    localparam logic [3:0] KEY_8   = 4'd9;
    localparam logic [3:0] KEY_9   = 4'd10;
    localparam logic [3:0] KEY_CE  = 4'd11;
    localparam logic [3:0] KEY_CA  = 4'd12;
    localparam logic [3:0] KEY_0   = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_LDR = 2'd2,
        S_RES = 2'd3
    } state_e;

    // Active-low row vector plus driven column -> key code; lowest low row wins.
    function automatic logic [3:0] key_decode(input logic [3:0] row_n, input logic [1:0] col_idx);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!row_n[i]) r = 2'(i);
        end
        return {r, col_idx};
    endfunction

    // {is_digit, value}
    function automatic logic [4:0] key_digit(input logic [3:0] code);
        logic [4:0] res;
        case (code)
            KEY_0:   res = {1'b1, 4'd0};
            KEY_1:   res = {1'b1, 4'd1};
            KEY_2:   res = {1'b1, 4'd2};
            KEY_3:   res = {1'b1, 4'd3};
            KEY_4:   res = {1'b1, 4'd4};
            KEY_5:   res = {1'b1, 4'd5};
            KEY_6:   res = {1'b1, 4'd6};
            KEY_7:   res = {1'b1, 4'd7};
            KEY_8:   res = {1'b1, 4'd8};
            KEY_9:   res = {1'b1, 4'd9};
            default: res = 5'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce.
//   clk, rst_n     : clock, asynchronous active-low reset
//   row[3:0]       : keypad rows, active-low
//   col[3:0]       : column drive, one-hot active-low
//   key_code[3:0]  : last debounced key (4*row+col)
//   key_valid      : one-cycle pulse per debounced press
//
// state      | meaning
// SC_SCAN    | cycling columns, rows sampled on last cycle of each slot
// SC_PRESS   | column frozen, counting stable cycles of the candidate code
// SC_RELEASE | key reported, waiting for DEBOUNCE cycles of all rows high
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {SC_SCAN, SC_PRESS, SC_RELEASE} scan_state_e;

    scan_state_e   sst_q, sst_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;

    logic          any_low;
    logic [3:0]    cur_code;

    assign any_low  = (row != 4'hF);
    assign cur_code = key_decode(row, col_idx_q);

    always_comb begin
        sst_d       = sst_q;
        col_idx_d   = col_idx_q;
        div_d       = div_q;
        deb_d       = deb_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        unique case (sst_q)
            SC_SCAN: begin
                if (div_q == '0) begin
                    div_d = DW'(SCAN_DIV - 1);
                    if (any_low) begin
                        // the sampling cycle counts as the first stable cycle
                        sst_d  = SC_PRESS;
                        cand_d = cur_code;
                        deb_d  = BW'(DEBOUNCE - 1);
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            SC_PRESS: begin
                if (!any_low) begin
                    sst_d = SC_SCAN;
                    div_d = DW'(SCAN_DIV - 1);
                end else if (cur_code != cand_q) begin
                    cand_d = cur_code;
                    deb_d  = BW'(DEBOUNCE - 1);
                end else if (deb_q <= BW'(1)) begin
                    key_valid_d = 1'b1;
                    key_code_d  = cand_q;
                    sst_d       = SC_RELEASE;
                    deb_d       = BW'(DEBOUNCE);
                end else begin
                    deb_d = deb_q - BW'(1);
                end
            end
            SC_RELEASE: begin
                if (any_low) begin
                    deb_d = BW'(DEBOUNCE);
                end else if (deb_q <= BW'(1)) begin
                    sst_d = SC_SCAN;
                    div_d = DW'(SCAN_DIV - 1);
                end else begin
                    deb_d = deb_q - BW'(1);
                end
            end
            default: sst_d = SC_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sst_q       <= SC_SCAN;
            col_idx_q   <= 2'd0;
            div_q       <= DW'(SCAN_DIV - 1);
            deb_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            sst_q       <= sst_d;
            col_idx_q   <= col_idx_d;
            div_q       <= div_d;
            deb_q       <= deb_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: rtl/calc_keypad_ctrl.sv
// Keypad entry and A op B = R sequencing controller for the calculator datapath.
//   CLK, CLR          : clock, asynchronous active-low reset
//   row / col         : 4x4 keypad rows in (active-low), columns out (one-hot active-low)
//   operand[W-1:0]    : accumulated decimal entry, fed to datapath A/B inputs
//   key_code, key_valid : debounced key report
//   Reset, LoadA, LoadB, LoadR : one-cycle datapath strobes (at most one per cycle)
//   AS                : 0 add / 1 subtract (level)
//   IUAU              : A-mux select, 1 = AU result
//   state[1:0]        : FSM state for debug
// Macro CALC_CHAIN_EN: + / - after a result loads R back into A (IUAU=1) to chain.
//
// state | meaning
// S_A   | entering operand A
// S_B   | entering operand B
// S_LDR | LoadB issued, LoadR goes out this cycle
// S_RES | result loaded, waiting for next entry
module calc_keypad_ctrl
    import calc_pkg::*;
#(
    parameter int W        = 16,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [3:0]   row,
    output logic [3:0]   col,
    output logic [W-1:0] operand,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic         Reset,
    output logic         LoadA,
    output logic         LoadB,
    output logic         LoadR,
    output logic         AS,
    output logic         IUAU,
    output logic [1:0]   state
);
    localparam int CW = $clog2(DIGITS + 1);

    if (((64'd1) << W) <= ((64'd10 ** DIGITS) - 64'd1)) begin : g_bad_width
        $error("calc_keypad_ctrl: W too small for DIGITS decimal digits");
    end

    state_e        st_q, st_d;
    logic [W-1:0]  entry_q, entry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          as_q, as_d;
    logic          kv_q, kv_d;
    logic          reset_c, load_a_c, load_b_c, load_r_c;
    logic [4:0]    dig;
`ifdef CALC_CHAIN_EN
    logic          chain_c;
`endif

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk       (CLK),
        .rst_n     (CLR),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    // The FSM reacts one cycle after key_valid; key_code holds until the next press.
    assign kv_d = key_valid;
    assign dig  = key_digit(key_code);

    always_comb begin
        st_d     = st_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        as_d     = as_q;
        reset_c  = 1'b0;
        load_a_c = 1'b0;
        load_b_c = 1'b0;
        load_r_c = 1'b0;
`ifdef CALC_CHAIN_EN
        chain_c  = 1'b0;
`endif
        if (st_q == S_LDR) begin
            load_r_c = 1'b1;
            st_d     = S_RES;
        end else if (kv_q) begin
            if (dig[4]) begin
                if (st_q == S_RES) begin
                    reset_c = 1'b1;
                    entry_d = W'(dig[3:0]);
                    cnt_d   = CW'(1);
                    st_d    = S_A;
                end else if (cnt_q < CW'(DIGITS)) begin
                    entry_d = entry_q * W'(10) + W'(dig[3:0]);
                    cnt_d   = cnt_q + CW'(1);
                end
            end else begin
                case (key_code)
                    KEY_ADD, KEY_SUB: begin
                        if (st_q == S_A) begin
                            load_a_c = 1'b1;
                            as_d     = (key_code == KEY_SUB);
                            entry_d  = '0;
                            cnt_d    = '0;
                            st_d     = S_B;
                        end
`ifdef CALC_CHAIN_EN
                        else if (st_q == S_RES) begin
                            load_a_c = 1'b1;
                            chain_c  = 1'b1;
                            as_d     = (key_code == KEY_SUB);
                            entry_d  = '0;
                            cnt_d    = '0;
                            st_d     = S_B;
                        end
`endif
                    end
                    KEY_EQ: begin
                        if (st_q == S_B) begin
                            load_b_c = 1'b1;
                            st_d     = S_LDR;
                        end
                    end
                    KEY_CE: begin
                        entry_d = '0;
                        cnt_d   = '0;
                    end
                    KEY_CA: begin
                        reset_c = 1'b1;
                        entry_d = '0;
                        cnt_d   = '0;
                        as_d    = 1'b0;
                        st_d    = S_A;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            st_q    <= S_A;
            entry_q <= '0;
            cnt_q   <= '0;
            as_q    <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            as_q    <= as_d;
            kv_q    <= kv_d;
        end
    end

    assign operand = entry_q;
    assign Reset   = reset_c;
    assign LoadA   = load_a_c;
    assign LoadB   = load_b_c;
    assign LoadR   = load_r_c;
    assign AS      = as_q;
    assign state   = st_q;
`ifdef CALC_CHAIN_EN
    assign IUAU    = chain_c;
`else
    assign IUAU    = 1'b0;
`endif

endmodule

// File: tb/tb_calc_keypad_ctrl.sv
module tb_calc_keypad_ctrl;
    localparam int W        = 12;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 8;
`ifdef CALC_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         CLR;
    logic [3:0]   row, col, key_code;
    logic [W-1:0] operand;
    logic         key_valid, Reset, LoadA, LoadB, LoadR, AS, IUAU;
    logic [1:0]   state;

    logic         pressed = 1'b0, pressed2 = 1'b0, glitch = 1'b0;
    logic [3:0]   press_code = 4'd0, press_code2 = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    // keypad face, indexed by 4*row+col; E = CE, C = CA, x = unused key
    string keymap = "123+456-789EC0=x";

    // reference model of the calculator entry rules
    int m_st = 0, m_entry = 0, m_cnt = 0;
    bit m_as = 1'b0;

    always #5 CLK = ~CLK;

    calc_keypad_ctrl #(
        .W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .CLK(CLK), .CLR(CLR), .row(row), .col(col), .operand(operand),
        .key_code(key_code), .key_valid(key_valid), .Reset(Reset),
        .LoadA(LoadA), .LoadB(LoadB), .LoadR(LoadR), .AS(AS), .IUAU(IUAU),
        .state(state)
    );

    // physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row = 4'hF;
        if (glitch) row = 4'b1110;
        else begin
            if (pressed && col[press_code[1:0]] == 1'b0) row[press_code[3:2]] = 1'b0;
            if (pressed2 && col[press_code2[1:0]] == 1'b0) row[press_code2[3:2]] = 1'b0;
        end
    end

    typedef struct {
        byte        key;
        logic [4:0] strb;     // {Reset, LoadA, LoadB, LoadR, IUAU} in the action cycle
        int         op;       // operand in the action cycle
        int         op_after;
        bit         as_after;
        int         st;
    } vec_t;

    typedef struct {
        logic [4:0] strb;
        int         op;
        int         op_after;
        bit         as_after;
        int         st;
    } obs_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int code_of(input byte ch);
        for (int i = 0; i < 16; i++) if (keymap[i] == ch) return i;
        return 15;
    endfunction

    task automatic model_step(input int code, output logic [4:0] strb, output int op_strobe);
        byte c;
        c = keymap[code];
        strb = 5'b0;
        op_strobe = m_entry;
        if (c >= "0" && c <= "9") begin
            if (m_st == 3) begin
                strb[4] = 1'b1; m_entry = c - "0"; m_cnt = 1; m_st = 0;
            end else if (m_cnt < DIGITS) begin
                m_entry = m_entry * 10 + (c - "0"); m_cnt++;
            end
        end else if (c == "+" || c == "-") begin
            if (m_st == 0 || (CHAIN && m_st == 3)) begin
                strb[3] = 1'b1;
                strb[0] = (m_st == 3);
                m_as = (c == "-"); m_entry = 0; m_cnt = 0; m_st = 1;
            end
        end else if (c == "=") begin
            if (m_st == 1) begin strb[2] = 1'b1; m_st = 3; end
        end else if (c == "E") begin
            m_entry = 0; m_cnt = 0;
        end else if (c == "C") begin
            strb[4] = 1'b1; m_entry = 0; m_cnt = 0; m_as = 1'b0; m_st = 0;
        end
    endtask

    task automatic do_key(input int code, output obs_t o);
        int n;
        o = '{default: 0};
        press_code = 4'(code);
        pressed = 1'b1;
        n = 0;
        @(negedge CLK);
        while (key_valid !== 1'b1 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("key_valid_seen", key_valid, 1);
        check("key_code", key_code, code);
        @(negedge CLK);
        check("key_valid_one_cycle", key_valid, 0);
        o.strb = {Reset, LoadA, LoadB, LoadR, IUAU};
        o.op   = int'(operand);
        if (LoadB === 1'b1) begin
            @(negedge CLK);
            check("loadr_after_loadb", {Reset, LoadA, LoadB, LoadR, IUAU}, 5'b00010);
        end
        @(negedge CLK);
        o.op_after = int'(operand);
        o.as_after = AS;
        o.st       = int'(state);
        pressed  = 1'b0;
        pressed2 = 1'b0;
        n = 0;
        repeat (DEBOUNCE + 4 * SCAN_DIV) begin
            @(negedge CLK);
            if (key_valid === 1'b1) n++;
        end
        check("no_auto_repeat", n, 0);
    endtask

    task automatic cmp_obs(input string tag, input obs_t o, input logic [4:0] strb, input int op,
                           input int op_after, input bit as_after, input int st);
        check({tag, ".strobes"}, o.strb, strb);
        check({tag, ".op_strobe"}, o.op, op);
        check({tag, ".operand"}, o.op_after, op_after);
        check({tag, ".AS"}, o.as_after, as_after);
        check({tag, ".state"}, o.st, st);
    endtask

    task automatic key_vs_model(input string tag, input int code);
        obs_t       o;
        logic [4:0] es;
        int         eop;
        model_step(code, es, eop);
        do_key(code, o);
        cmp_obs(tag, o, es, eop, m_entry, m_as, m_st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[$];
        obs_t       o;
        logic [4:0] es;
        int         eop, kv_cnt;
        logic [3:0] c0;

        tbl.push_back('{"1", 5'b00000,  0,   1, 1'b0, 0});
        tbl.push_back('{"2", 5'b00000,  1,  12, 1'b0, 0});
        tbl.push_back('{"+", 5'b01000, 12,   0, 1'b0, 1});
        tbl.push_back('{"+", 5'b00000,  0,   0, 1'b0, 1});
        tbl.push_back('{"3", 5'b00000,  0,   3, 1'b0, 1});
        tbl.push_back('{"=", 5'b00100,  3,   3, 1'b0, 3});
`ifdef CALC_CHAIN_EN
        tbl.push_back('{"-", 5'b01001,  3,   0, 1'b1, 1});
        tbl.push_back('{"C", 5'b10000,  0,   0, 1'b0, 0});
`else
        tbl.push_back('{"-", 5'b00000,  3,   3, 1'b0, 3});
        tbl.push_back('{"C", 5'b10000,  3,   0, 1'b0, 0});
`endif
        tbl.push_back('{"1", 5'b00000,  0,   1, 1'b0, 0});
        tbl.push_back('{"2", 5'b00000,  1,  12, 1'b0, 0});
        tbl.push_back('{"3", 5'b00000, 12, 123, 1'b0, 0});
        tbl.push_back('{"4", 5'b00000,123, 123, 1'b0, 0});
        tbl.push_back('{"E", 5'b00000,123,   0, 1'b0, 0});
        tbl.push_back('{"=", 5'b00000,  0,   0, 1'b0, 0});
        tbl.push_back('{"7", 5'b00000,  0,   7, 1'b0, 0});
        tbl.push_back('{"-", 5'b01000,  7,   0, 1'b1, 1});
        tbl.push_back('{"5", 5'b00000,  0,   5, 1'b1, 1});
        tbl.push_back('{"C", 5'b10000,  5,   0, 1'b0, 0});
        tbl.push_back('{"2", 5'b00000,  0,   2, 1'b0, 0});
        tbl.push_back('{"+", 5'b01000,  2,   0, 1'b0, 1});
        tbl.push_back('{"9", 5'b00000,  0,   9, 1'b0, 1});
        tbl.push_back('{"=", 5'b00100,  9,   9, 1'b0, 3});
        tbl.push_back('{"E", 5'b00000,  9,   0, 1'b0, 3});
        tbl.push_back('{"4", 5'b10000,  0,   4, 1'b0, 0});

        // reset values
        CLR = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst.col", col, 4'b1110);
        check("rst.operand", operand, 0);
        check("rst.outputs", {Reset, LoadA, LoadB, LoadR, IUAU, AS, key_valid}, 0);
        check("rst.key_code", key_code, 0);
        check("rst.state", state, 0);
        CLR = 1'b1;
        @(negedge CLK);
        check("post_rst.col", col, 4'b1110);
        check("post_rst.state", state, 0);

        // short row glitch must not produce a key, and scanning must carry on
        glitch = 1'b1;
        repeat (5) @(negedge CLK);
        glitch = 1'b0;
        kv_cnt = 0;
        repeat (30) begin
            @(negedge CLK);
            if (key_valid === 1'b1) kv_cnt++;
        end
        check("glitch.no_key", kv_cnt, 0);
        c0 = col;
        repeat (SCAN_DIV + 1) @(negedge CLK);
        check("glitch.scan_resumed", (col != c0), 1);
        check("glitch.state", state, 0);

        // directed table
        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            model_step(code_of(tbl[i].key), es, eop);
            do_key(code_of(tbl[i].key), o);
            cmp_obs(tag, o, tbl[i].strb, tbl[i].op, tbl[i].op_after, tbl[i].as_after, tbl[i].st);
        end

        // two keys in one column: lower row index reported (3 over 9)
        key_vs_model("ca_pre_multi", code_of("C"));
        press_code2 = 4'(code_of("9"));
        pressed2 = 1'b1;
        key_vs_model("multi_row", code_of("3"));

        // randomized keys against the model
        for (int i = 0; i < 60; i++) begin
            int code;
            code = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                               : int'($urandom_range(0, 10)));
            key_vs_model($sformatf("rnd%0d", i), code);
        end

        // CLR mid-sequence
        key_vs_model("abort_ca", code_of("C"));
        key_vs_model("abort_sub", code_of("-"));
        key_vs_model("abort_6", code_of("6"));
        #2 CLR = 1'b0;
        #1;
        check("abort.operand", operand, 0);
        check("abort.AS", AS, 0);
        check("abort.state", state, 0);
        check("abort.col", col, 4'b1110);
        @(negedge CLK);
        CLR = 1'b1;
        m_st = 0; m_entry = 0; m_cnt = 0; m_as = 1'b0;
        key_vs_model("post_abort_8", code_of("8"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
